// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritizing interrupt controller with NMI path and config registers
module interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int IDW     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               nmi_in,
    input  logic               int_ack,
    input  logic               eoi,
    input  logic               nmi_ack,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [NUM_IRQ-1:0] cfg_wdata,
    output logic [NUM_IRQ-1:0] cfg_rdata,
    output logic               INT,
    output logic               INTD,
    output logic               NMI,
    output logic [IDW-1:0]     int_vec
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ:0]   sync1, sync2, hist, rise;
    logic [NUM_IRQ-1:0] pending, mask, in_service, eligible;
    logic [NUM_IRQ-1:0] vec_onehot, ack_clr, w1c_clr;
    logic               gdis, nmi_flag;
    logic [IDW-1:0]     winner;
    logic               latch_vec, take_ack, take_eoi;

    // Top bit of the synchronizer chain carries nmi_in alongside the irq lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= {nmi_in, irq};
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise       = sync2 & ~hist;
    assign eligible   = pending & mask;
    assign vec_onehot = NUM_IRQ'(1) << int_vec;

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDW'(i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|eligible && !gdis) state_nxt = REQ;
            REQ: begin
                if (int_ack)                                     state_nxt = SERVICE;
                else if (!(|(eligible & vec_onehot)) || gdis)    state_nxt = IDLE;
            end
            SERVICE: if (eoi) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        INT       = (state == REQ);
        INTD      = gdis | (state != IDLE);
        latch_vec = (state == IDLE) && (state_nxt == REQ);
        take_ack  = (state == REQ) && int_ack;
        take_eoi  = (state == SERVICE) && eoi;
    end

    assign ack_clr = take_ack ? vec_onehot : '0;
    assign w1c_clr = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : '0;

    // New edges override same-cycle clears so a request is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            mask       <= '0;
            gdis       <= 1'b1;
            in_service <= '0;
            int_vec    <= '0;
            nmi_flag   <= 1'b0;
        end else begin
            pending  <= (pending & ~w1c_clr & ~ack_clr) | rise[NUM_IRQ-1:0];
            nmi_flag <= rise[NUM_IRQ] | (nmi_flag & ~nmi_ack);
            if (cfg_we && cfg_addr == 2'd0) mask <= cfg_wdata;
            if (cfg_we && cfg_addr == 2'd2) gdis <= cfg_wdata[0];
            if (take_ack)      in_service <= in_service | vec_onehot;
            else if (take_eoi) in_service <= '0;
            if (latch_vec) int_vec <= winner;
        end
    end

    assign NMI = nmi_flag;

    always_comb begin
        unique case (cfg_addr)
            2'd0:    cfg_rdata = mask;
            2'd1:    cfg_rdata = pending;
            2'd2:    cfg_rdata = {{(NUM_IRQ-1){1'b0}}, gdis};
            2'd3:    cfg_rdata = in_service;
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - table, directed and randomized checks of interrupt_controller
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq;
    logic       nmi_in, int_ack, eoi, nmi_ack, cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata, cfg_rdata;
    logic       INT, INTD, NMI;
    logic [2:0] int_vec;

    int n_vec = 0;
    int n_err = 0;

    interrupt_controller #(.NUM_IRQ(8), .IDW(3)) dut (
        .clk(clk), .reset(reset), .irq(irq), .nmi_in(nmi_in), .int_ack(int_ack),
        .eoi(eoi), .nmi_ack(nmi_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .INT(INT), .INTD(INTD),
        .NMI(NMI), .int_vec(int_vec)
    );

    always #5 clk = ~clk;

    // Reference model: request history per sampled clock, plus a handshake phase
    // (0 waiting, 1 presented to CPU, 2 handler running).
    logic [7:0] smp [4];
    logic       nsmp [4];
    logic [7:0] m_pend, m_mask, m_isr;
    logic       m_gdis, m_nmi;
    int         m_phase, m_vec;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;
    reg_vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] e);
        for (int i = 0; i < 8; i++) if (e[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin smp[j] = '0; nsmp[j] = 1'b0; end
        m_pend = '0; m_mask = '0; m_isr = '0; m_gdis = 1'b1; m_nmi = 1'b0;
        m_phase = 0; m_vec = 0;
    endtask

    task automatic model_step();
        logic [7:0] elig, clr, edges, nisr;
        logic       nedge;
        int         nphase, nvec;
        for (int j = 3; j > 0; j--) begin smp[j] = smp[j-1]; nsmp[j] = nsmp[j-1]; end
        smp[0] = irq; nsmp[0] = nmi_in;
        edges = smp[2] & ~smp[3];
        nedge = nsmp[2] & ~nsmp[3];
        elig = m_pend & m_mask;
        clr = '0; nphase = m_phase; nvec = m_vec; nisr = m_isr;
        if (m_phase == 0) begin
            if (elig != 0 && !m_gdis) begin nphase = 1; nvec = lowest(elig); end
        end else if (m_phase == 1) begin
            if (int_ack) begin nphase = 2; clr[m_vec] = 1'b1; nisr[m_vec] = 1'b1; end
            else if (!elig[m_vec] || m_gdis) nphase = 0;
        end else if (eoi) begin
            nphase = 0; nisr = '0;
        end
        if (cfg_we && cfg_addr == 2'd1) clr = clr | cfg_wdata;
        m_pend = (m_pend & ~clr) | edges;
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
        if (cfg_we && cfg_addr == 2'd2) m_gdis = cfg_wdata[0];
        m_nmi = nedge | (m_nmi & ~nmi_ack);
        m_phase = nphase; m_vec = nvec; m_isr = nisr;
    endtask

    task automatic model_check();
        logic [7:0] exp_rd;
        case (cfg_addr)
            2'd0:    exp_rd = m_mask;
            2'd1:    exp_rd = m_pend;
            2'd2:    exp_rd = {7'd0, m_gdis};
            default: exp_rd = m_isr;
        endcase
        chk("model_int",   INT,  m_phase == 1);
        chk("model_intd",  INTD, m_gdis || m_phase != 0);
        chk("model_nmi",   NMI,  m_nmi);
        chk("model_vec",   int_vec, m_vec);
        chk("model_rdata", cfg_rdata, exp_rd);
    endtask

    // Inputs are changed 1 time unit after a rising edge; pulses last one cycle.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
        int_ack = 1'b0; eoi = 1'b0; nmi_ack = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b0; irq = '0; nmi_in = 1'b0; int_ack = 1'b0; eoi = 1'b0;
        nmi_ack = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        model_reset();
        #12;
        chk("rst_int", INT, 1'b0);
        chk("rst_intd", INTD, 1'b1);
        chk("rst_nmi", NMI, 1'b0);
        chk("rst_vec", int_vec, 3'd0);
        chk("rst_mask", cfg_rdata, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        // Register access table.
        tbl[0] = '{1'b1, 2'd0, 8'hA5, 8'hA5};
        tbl[1] = '{1'b0, 2'd2, 8'h00, 8'h01};
        tbl[2] = '{1'b1, 2'd2, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 2'd2, 8'hFE, 8'h00};
        tbl[4] = '{1'b1, 2'd2, 8'hFF, 8'h01};
        tbl[5] = '{1'b1, 2'd3, 8'hFF, 8'h00};
        tbl[6] = '{1'b1, 2'd1, 8'hFF, 8'h00};
        tbl[7] = '{1'b0, 2'd0, 8'h00, 8'hA5};
        tbl[8] = '{1'b1, 2'd0, 8'h3C, 8'h3C};
        for (int i = 0; i < 9; i++) begin
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].wdata;
            tick();
            chk("tbl_rdata", cfg_rdata, tbl[i].exp);
        end

        // Enable, single request with 4-cycle latency.
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h00);
        cfg_addr = 2'd1;
        pulse_irq(8'h20);
        tick(); chk("lat_k1", INT, 1'b0);
        tick(); chk("lat_k2", INT, 1'b0);
        chk("lat_pend", cfg_rdata, 8'h20);
        tick(); chk("lat_k3", INT, 1'b1);
        chk("lat_vec", int_vec, 3'd5);
        chk("lat_intd", INTD, 1'b1);
        int_ack = 1'b1; tick();
        chk("ack_int", INT, 1'b0);
        chk("ack_pend", cfg_rdata, 8'h00);
        eoi = 1'b1; tick();
        chk("eoi_intd", INTD, 1'b0);

        // Simultaneous edges: priority, then the loser after eoi.
        pulse_irq(8'h44);
        wait_ticks(3);
        chk("pri_vec", int_vec, 3'd2);
        int_ack = 1'b1; tick();
        eoi = 1'b1; tick();
        chk("pri_eoi_int", INT, 1'b0);
        tick();
        chk("pri_reint", INT, 1'b1);
        chk("pri_vec6", int_vec, 3'd6);
        int_ack = 1'b1; tick();
        eoi = 1'b1; tick();

        // Masked request, unmask, then W1C withdrawal while presented.
        wr(2'd0, 8'hF7);
        cfg_addr = 2'd1;
        pulse_irq(8'h08);
        wait_ticks(4);
        chk("msk_int", INT, 1'b0);
        chk("msk_pend", cfg_rdata, 8'h08);
        wr(2'd0, 8'hFF);
        tick();
        chk("unmsk_int", INT, 1'b1);
        chk("unmsk_vec", int_vec, 3'd3);
        wr(2'd1, 8'h08);
        tick();
        chk("w1c_int", INT, 1'b0);

        // No preemption while in service.
        pulse_irq(8'h02);
        wait_ticks(3);
        int_ack = 1'b1; tick();
        pulse_irq(8'h01);
        wait_ticks(4);
        chk("svc_int", INT, 1'b0);
        cfg_addr = 2'd1; #1;
        chk("svc_pend", cfg_rdata, 8'h01);
        cfg_addr = 2'd3; #1;
        chk("svc_isr", cfg_rdata, 8'h02);
        eoi = 1'b1; tick();
        tick();
        chk("svc_reint", INT, 1'b1);
        chk("svc_vec0", int_vec, 3'd0);
        int_ack = 1'b1; tick();

        // NMI independent of gdis and service state; set beats ack.
        wr(2'd2, 8'h01);
        nmi_in = 1'b1; tick(); nmi_in = 1'b0;
        tick(); chk("nmi_k1", NMI, 1'b0);
        tick(); chk("nmi_k2", NMI, 1'b1);
        nmi_in = 1'b1; tick(); nmi_in = 1'b0;
        tick();
        nmi_ack = 1'b1; tick();
        chk("nmi_setwins", NMI, 1'b1);
        nmi_ack = 1'b1; tick();
        chk("nmi_acked", NMI, 1'b0);
        eoi = 1'b1; tick();

        // Asynchronous reset while INT is asserted.
        wr(2'd2, 8'h00);
        nmi_in = 1'b1; pulse_irq(8'h80); nmi_in = 1'b0;
        wait_ticks(3);
        chk("pre_rst_int", INT, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_int", INT, 1'b0);
        chk("arst_nmi", NMI, 1'b0);
        chk("arst_intd", INTD, 1'b1);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            chk("arst_rdata", cfg_rdata, (a == 2) ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        reset = 1'b1;
        wait_ticks(2);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            irq      = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            nmi_in   = ($urandom_range(7) == 0) ? ~nmi_in : nmi_in;
            int_ack  = ($urandom_range(3) == 0);
            eoi      = ($urandom_range(4) == 0);
            nmi_ack  = ($urandom_range(5) == 0);
            cfg_addr = 2'($urandom_range(3));
            cfg_we   = ($urandom_range(6) == 0);
            cfg_wdata = 8'($urandom);
            if (cfg_addr == 2'd2) cfg_wdata[0] = ($urandom_range(3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
